mem_io_ctrl: RTL and testbench

Memory-side bus controller sitting directly downstream of the CPU's memory port. It consumes `mem_cmd`/`mem_addr`/`write_data` each cycle, steers accesses to an external 256-word synchronous RAM or to on-block I/O registers (LEDs, switches, timer, status), and returns `read_data` with a uniform one-cycle read latency that matches the CPU's two-cycle fetch/load sequence.

---
 rtl/mem_io_ctrl.sv | 163 ++++++++++++++++
 tb/tb_mem_io_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_ctrl.sv
// mem_io_ctrl: memory-side bus controller behind the CPU memory port.
//   Steers each CPU access either to an external 256-word synchronous RAM
//   (0x000-0x0FF) or to on-block I/O registers:
//     0x100 LED (R/W, 8 bit), 0x140 SW (R), 0x141 TIMER (R/W),
//     0x142 STATUS (R, write-1-to-clear); everything else is unmapped.
//   Reads have a uniform one-clock latency for RAM and I/O alike.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   mem_cmd           01 read, 10 write, 00/11 idle
//   mem_addr          9-bit word address
//   write_data        store data
//   read_data         load/fetch data (valid the clock after a read)
//   ram_addr/ram_din  RAM address / write data (combinational pass-through)
//   ram_we            RAM write enable (combinational)
//   ram_dout          RAM read data, one clock after address
//   sw_in             asynchronous switch inputs
//   ledr_out          LED register
//   irq_tick          one-cycle pulse per timer increment
module mem_io_ctrl #(
  parameter int PRESCALE = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mem_cmd,
  input  logic [8:0]  mem_addr,
  input  logic [15:0] write_data,
  output logic [15:0] read_data,
  output logic [7:0]  ram_addr,
  output logic [15:0] ram_din,
  output logic        ram_we,
  input  logic [15:0] ram_dout,
  input  logic [7:0]  sw_in,
  output logic [7:0]  ledr_out,
  output logic        irq_tick
);

  localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  localparam logic [8:0] A_LED = 9'h100;
  localparam logic [8:0] A_SW  = 9'h140;
  localparam logic [8:0] A_TMR = 9'h141;
  localparam logic [8:0] A_ST  = 9'h142;

  // decoded access for the current cycle
  typedef struct packed {
    logic rd;
    logic wr;
    logic ram;
    logic led;
    logic sw;
    logic tmr;
    logic st;
    logic unm;
  } dec_t;

  dec_t          dec;
  logic [15:0]   io_val;
  logic          sel_ram_q;
  logic [15:0]   io_rdata_q;
  logic [7:0]    sw_s1, sw_s2;
  logic [PW-1:0] pre_cnt;
  logic [15:0]   tmr_cnt;
  logic [1:0]    status;
  logic          tick_due;
  logic          tmr_wr;
  logic          ovf_set;
  logic [1:0]    st_clr;

  // ---------------- decode ----------------
  always_comb begin
    dec     = '0;
    dec.rd  = (mem_cmd == 2'b01);
    dec.wr  = (mem_cmd == 2'b10);
    dec.ram = ~mem_addr[8];
    dec.led = (mem_addr == A_LED);
    dec.sw  = (mem_addr == A_SW);
    dec.tmr = (mem_addr == A_TMR);
    dec.st  = (mem_addr == A_ST);
    dec.unm = ~(dec.ram | dec.led | dec.sw | dec.tmr | dec.st);
  end

  assign ram_addr = mem_addr[7:0];
  assign ram_din  = write_data;
  assign ram_we   = dec.wr & dec.ram;

  // I/O read mux; unmapped and RAM addresses yield zero here
  always_comb begin
    io_val = '0;
    if (dec.led) io_val = {8'h00, ledr_out};
    if (dec.sw)  io_val = {8'h00, sw_s2};
    if (dec.tmr) io_val = tmr_cnt;
    if (dec.st)  io_val = {14'h0000, status};
  end

  // ---------------- read path ----------------
  // RAM data arrives a clock after the address, so only the select is
  // registered for RAM; I/O data is captured here to match that latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_ram_q  <= 1'b0;
      io_rdata_q <= '0;
    end else if (dec.rd) begin
      sel_ram_q <= dec.ram;
      if (!dec.ram) io_rdata_q <= io_val;
    end
  end

  assign read_data = sel_ram_q ? ram_dout : io_rdata_q;

  // ---------------- switches ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= sw_in;
      sw_s2 <= sw_s1;
    end
  end

  // ---------------- LED ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                ledr_out <= '0;
    else if (dec.wr & dec.led) ledr_out <= write_data[7:0];
  end

  // ---------------- timer ----------------
  // A TIMER write takes priority over the tick: it reloads the count,
  // restarts the prescaler and suppresses both increment and irq.
  assign tick_due = (pre_cnt == PRE_LAST);
  assign tmr_wr   = dec.wr & dec.tmr;
  assign ovf_set  = tick_due & ~tmr_wr & (tmr_cnt == 16'hFFFF);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_cnt  <= '0;
      tmr_cnt  <= '0;
      irq_tick <= 1'b0;
    end else begin
      irq_tick <= tick_due & ~tmr_wr;
      if (tmr_wr) begin
        pre_cnt <= '0;
        tmr_cnt <= write_data;
      end else if (tick_due) begin
        pre_cnt <= '0;
        tmr_cnt <= tmr_cnt + 16'd1;
      end else begin
        pre_cnt <= pre_cnt + 1'b1;
      end
    end
  end

  // ---------------- status ----------------
  // Sticky sets are OR-ed in after the W1C mask so a set wins a same-cycle clear.
  assign st_clr = (dec.wr & dec.st) ? write_data[1:0] : 2'b00;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) status <= '0;
    else        status <= (status & ~st_clr) | {(dec.rd | dec.wr) & dec.unm, ovf_set};
  end

endmodule

// File: tb/tb_mem_io_ctrl.sv
module tb_mem_io_ctrl;
  localparam int P = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic [7:0]  ram_addr;
  logic [15:0] ram_din;
  logic        ram_we;
  logic [15:0] ram_dout;
  logic [7:0]  sw_in;
  logic [7:0]  ledr_out;
  logic        irq_tick;

  always #5 clk = ~clk;

  mem_io_ctrl #(.PRESCALE(P)) dut (
    .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
    .write_data(write_data), .read_data(read_data), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout), .sw_in(sw_in),
    .ledr_out(ledr_out), .irq_tick(irq_tick)
  );

  // external synchronous RAM, read-before-write
  logic [15:0] ram [256];
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_din;
    ram_dout <= ram[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  // Timer is described arithmetically: count after edge e is the last
  // loaded value plus the number of whole PRESCALE periods since the load.
  logic [15:0] m_mem [256];
  logic [7:0]  m_led;
  logic [15:0] m_base;
  int          m_lr;
  logic [1:0]  m_st;
  logic [7:0]  sw_hist [int];
  bit          m_last_io;
  logic [15:0] m_last_val;

  typedef struct {
    int          due;
    bit          rd_chk;
    logic [15:0] rd_val;
    logic [7:0]  led;
    bit          irq;
  } exp_t;
  exp_t q[$];

  function automatic logic [15:0] cnt_after(input int e);
    return m_base + 16'((e - m_lr) / P);
  endfunction

  function automatic logic [7:0] sw_at(input int e);
    if (sw_hist.exists(e)) return sw_hist[e];
    return 8'h00;
  endfunction

  task automatic model_reset();
    m_led      = 8'h00;
    m_base     = 16'h0000;
    m_lr       = cyc;
    m_st       = 2'b00;
    sw_hist[cyc]     = 8'h00;
    sw_hist[cyc - 1] = 8'h00;
    m_last_io  = 1'b1;
    m_last_val = 16'h0000;
  endtask

  // one bus cycle: drive, predict, queue the expectation
  task automatic do_op(input logic [1:0] cmd, input logic [8:0] a,
                       input logic [15:0] wd, input logic [7:0] sw);
    int          e;
    exp_t        x;
    bit          rd, wr, isram, unm, inc, ovf;
    logic [15:0] v;
    @(negedge clk);
    e = cyc + 1;
    mem_cmd = cmd; mem_addr = a; write_data = wd; sw_in = sw;
    sw_hist[e] = sw;
    rd    = (cmd == 2'b01);
    wr    = (cmd == 2'b10);
    isram = (a < 9'h100);
    unm   = (rd || wr) && !isram && !(a inside {9'h100, 9'h140, 9'h141, 9'h142});
    v = 16'h0000;
    if (rd) begin
      if (isram) v = m_mem[a[7:0]];
      else case (a)
        9'h100:  v = {8'h00, m_led};
        9'h140:  v = {8'h00, sw_at(e - 2)};
        9'h141:  v = cnt_after(e - 1);
        9'h142:  v = {14'h0, m_st};
        default: v = 16'h0000;
      endcase
    end
    inc = !(wr && a == 9'h141) && ((e - m_lr) % P == 0);
    ovf = inc && (cnt_after(e) == 16'h0000);
    m_st = (m_st & ~((wr && a == 9'h142) ? wd[1:0] : 2'b00)) | {unm, ovf};
    if (wr && a == 9'h141) begin m_base = wd; m_lr = e; end
    if (wr && a == 9'h100) m_led = wd[7:0];
    if (wr && isram) m_mem[a[7:0]] = wd;
    if (rd) begin m_last_io = !isram; m_last_val = v; end
    x.due = e; x.rd_chk = rd || m_last_io; x.rd_val = m_last_val;
    x.led = m_led; x.irq = inc;
    q.push_back(x);
    #1;
    chk("ram_we", {15'h0, ram_we}, {15'h0, wr && isram});
    chk("ram_addr", {8'h00, ram_addr}, {8'h00, a[7:0]});
    if (wr && isram) chk("ram_din", ram_din, wd);
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      while (q.size() > 0 && q[0].due <= cyc) begin
        x = q.pop_front();
        if (x.rd_chk) chk("read_data", read_data, x.rd_val);
        chk("ledr_out", {8'h00, ledr_out}, {8'h00, x.led});
        chk("irq_tick", {15'h0, irq_tick}, {15'h0, x.irq});
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [8:0] rand_addr();
    logic [8:0] un [4];
    un[0] = 9'h101; un[1] = 9'h143; un[2] = 9'h1F0; un[3] = 9'h1FF;
    case ($urandom_range(9))
      0, 1, 2, 3: return 9'($urandom_range(15));
      4:          return ($urandom_range(1) != 0) ? 9'h050 : 9'h0FF;
      5:          return 9'h100;
      6:          return 9'h140;
      7:          return 9'h141;
      8:          return 9'h142;
      default:    return un[$urandom_range(3)];
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int          irq_cnt;
    logic [7:0]  sw;
    logic [1:0]  cmd;
    logic [8:0]  a;
    logic [15:0] wd;

    reset = 1'b0; mem_cmd = 2'b00; mem_addr = '0; write_data = '0; sw_in = '0;
    #1;
    chk("rst_read_data", read_data, 16'h0000);
    chk("rst_ledr", {8'h00, ledr_out}, 16'h0000);
    chk("rst_irq", {15'h0, irq_tick}, 16'h0000);
    chk("rst_ram_we", {15'h0, ram_we}, 16'h0000);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    model_reset();

    // preload the RAM words the bench uses
    for (int i = 0; i < 16; i++) do_op(2'b10, 9'(i), 16'($urandom), 8'h00);
    do_op(2'b10, 9'h0FF, 16'($urandom), 8'h00);

    // RAM write then held read
    do_op(2'b10, 9'h050, 16'hBEEF, 8'h00);
    do_op(2'b01, 9'h050, 16'h0000, 8'h00);
    do_op(2'b01, 9'h050, 16'h0000, 8'h00);
    do_op(2'b00, 9'h050, 16'h0000, 8'h00);

    // LED
    do_op(2'b10, 9'h100, 16'h12A5, 8'h00);
    do_op(2'b01, 9'h100, 16'h0000, 8'h00);
    do_op(2'b00, 9'h000, 16'h0000, 8'h00);

    // switch synchronizer latency
    do_op(2'b00, 9'h000, 16'h0000, 8'h3C);
    do_op(2'b00, 9'h000, 16'h0000, 8'h3C);
    do_op(2'b01, 9'h140, 16'h0000, 8'h3C);
    do_op(2'b01, 9'h140, 16'h0000, 8'h81);
    do_op(2'b00, 9'h000, 16'h0000, 8'h81);

    // timer wrap and overflow
    do_op(2'b10, 9'h141, 16'hFFFE, 8'h81);
    irq_cnt = 0;
    repeat (8) begin
      do_op(2'b00, 9'h000, 16'h0000, 8'h81);
      @(posedge clk);
      #1 irq_cnt += int'(irq_tick);
    end
    chk("irq_count", 16'(irq_cnt), 16'd2);
    do_op(2'b01, 9'h141, 16'h0000, 8'h81);
    do_op(2'b01, 9'h142, 16'h0000, 8'h81);
    do_op(2'b10, 9'h142, 16'h0001, 8'h81);
    do_op(2'b01, 9'h142, 16'h0000, 8'h81);

    // unmapped accesses
    do_op(2'b01, 9'h1F0, 16'h0000, 8'h81);
    do_op(2'b01, 9'h142, 16'h0000, 8'h81);
    do_op(2'b10, 9'h1F0, 16'hFFFF, 8'h81);
    do_op(2'b01, 9'h100, 16'h0000, 8'h81);

    // W1C in the same cycle as an overflow
    do_op(2'b10, 9'h141, 16'hFFFF, 8'h81);
    repeat (3) do_op(2'b00, 9'h000, 16'h0000, 8'h81);
    do_op(2'b10, 9'h142, 16'h0003, 8'h81);
    do_op(2'b01, 9'h142, 16'h0000, 8'h81);

    // randomized traffic
    sw = 8'h81;
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(19))
        0, 1, 2, 3, 4, 5, 6, 7:  cmd = 2'b01;
        8, 9, 10, 11, 12, 13, 14: cmd = 2'b10;
        15, 16, 17, 18:           cmd = 2'b00;
        default:                  cmd = 2'b11;
      endcase
      a  = rand_addr();
      wd = 16'($urandom);
      if (a == 9'h141 && $urandom_range(1) != 0) wd = 16'hFFF0 + 16'($urandom_range(15));
      if ($urandom_range(3) == 0) sw = 8'($urandom);
      do_op(cmd, a, wd, sw);
    end

    // asynchronous reset in the middle of an LED write
    do_op(2'b10, 9'h100, 16'h0077, sw);
    do_op(2'b00, 9'h000, 16'h0000, sw);
    @(negedge clk);
    mem_cmd = 2'b10; mem_addr = 9'h100; write_data = 16'h1255;
    #2 reset = 1'b0;
    #1;
    chk("async_rst_ledr", {8'h00, ledr_out}, 16'h0000);
    chk("async_rst_read_data", read_data, 16'h0000);
    chk("async_rst_irq", {15'h0, irq_tick}, 16'h0000);
    q.delete();
    repeat (2) @(posedge clk);
    #1 chk("rst_held_ledr", {8'h00, ledr_out}, 16'h0000);
    mem_cmd = 2'b00;
    @(posedge clk);
    #2 reset = 1'b1;
    model_reset();
    do_op(2'b00, 9'h000, 16'h0000, 8'h00);
    do_op(2'b01, 9'h100, 16'h0000, 8'h00);
    do_op(2'b01, 9'h141, 16'h0000, 8'h00);
    repeat (6) do_op(2'b00, 9'h000, 16'h0000, 8'h00);
    do_op(2'b01, 9'h141, 16'h0000, 8'h00);
    do_op(2'b00, 9'h000, 16'h0000, 8'h00);

    @(posedge clk);
    #2 chk("sb_drained", 16'(q.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
